// File: rtl/miriscv_pkg.sv
// Shared types for the data-memory arbiter: FSM state encoding and master-side request bundle.
// Pure declarations, no timing; latency and backpressure live in the modules that import this package.
package miriscv_pkg;

   localparam int ARB_MASTERS = 2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/miriscv_rr_arbiter.sv
// Combinational two-master winner select: lone requester wins; ties go round-robin or to m0.
// Zero latency; no backpressure of its own, the losing request simply stays pending upstream.
module miriscv_rr_arbiter
   import miriscv_pkg::*;
#(
   parameter int ROUND_ROBIN = 1
)
(
   input  logic [ARB_MASTERS-1:0] reqs,
   input  logic                   last_owner,
   output logic                   grant_idx
);

   always_comb begin
      grant_idx = 1'b0;
      if (reqs[1] && !reqs[0]) begin
         grant_idx = 1'b1;
      end else if (reqs[1] && reqs[0]) begin
         // tie: alternate away from the previous owner, or let the LSU win
         grant_idx = (ROUND_ROBIN != 0) ? ~last_owner : 1'b0;
      end
   end

endmodule

// File: rtl/miriscv_dmem_arbiter.sv
// Two-master data-memory arbiter: IDLE grants, ACCESS drives memory, RESP returns one rvalid pulse.
// Latency 3 cycles per access; a pending master sees stall_o until its rvalid cycle.
module miriscv_dmem_arbiter
   import miriscv_pkg::*;
#(
   parameter int ROUND_ROBIN = 1
)
(
   input  logic        clk,
   input  logic        rst_i,

   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [3:0]  m0_be_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   output logic        m0_stall_o,
   output logic        m0_rvalid_o,
   output logic [31:0] m0_rdata_o,

   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [3:0]  m1_be_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   output logic        m1_stall_o,
   output logic        m1_rvalid_o,
   output logic [31:0] m1_rdata_o,

   output logic        data_req_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic [31:0] data_rdata_i
);

   arb_state_t             state_q;
   logic                   owner_q;
   logic                   last_owner_q;
   logic                   owner_we_q;
   logic                   grant_idx;
   logic [ARB_MASTERS-1:0] reqs;
   mem_req_t               m0_acc;
   mem_req_t               m1_acc;
   mem_req_t               own_acc;
   logic                   in_access;
   logic                   in_resp;
   logic [31:0]            resp_data;

   assign reqs    = {m1_req_i, m0_req_i};
   assign m0_acc  = '{we: m0_we_i, be: m0_be_i, addr: m0_addr_i, wdata: m0_wdata_i};
   assign m1_acc  = '{we: m1_we_i, be: m1_be_i, addr: m1_addr_i, wdata: m1_wdata_i};
   assign own_acc = owner_q ? m1_acc : m0_acc;

   miriscv_rr_arbiter #(
      .ROUND_ROBIN (ROUND_ROBIN)
   ) u_rr_arbiter (
      .reqs       (reqs),
      .last_owner (last_owner_q),
      .grant_idx  (grant_idx)
   );

   always_ff @(posedge clk) begin
      if (rst_i) begin
         state_q      <= IDLE;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         owner_we_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|reqs) begin
                  owner_q      <= grant_idx;
                  last_owner_q <= grant_idx;
                  state_q      <= ACCESS;
               end
            end
            ACCESS: begin
               // remember what was actually issued so RESP knows read vs write
               owner_we_q <= own_acc.we;
               state_q    <= RESP;
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // outputs are forced quiet while reset is asserted, even mid-access
   assign in_access = (state_q == ACCESS) && !rst_i;
   assign in_resp   = (state_q == RESP) && !rst_i;
   assign resp_data = owner_we_q ? 32'h0 : data_rdata_i;

   always_comb begin
      data_req_o   = in_access;
      data_we_o    = 1'b0;
      data_be_o    = 4'h0;
      data_addr_o  = 32'h0;
      data_wdata_o = 32'h0;
      if (in_access) begin
         data_we_o    = own_acc.we;
         data_be_o    = own_acc.be;
         data_addr_o  = own_acc.addr;
         data_wdata_o = own_acc.wdata;
      end
   end

   assign m0_rvalid_o = in_resp && !owner_q;
   assign m1_rvalid_o = in_resp && owner_q;
   assign m0_rdata_o  = m0_rvalid_o ? resp_data : 32'h0;
   assign m1_rdata_o  = m1_rvalid_o ? resp_data : 32'h0;
   assign m0_stall_o  = m0_req_i & ~m0_rvalid_o;
   assign m1_stall_o  = m1_req_i & ~m1_rvalid_o;

endmodule

// File: tb/tb_miriscv_dmem_arbiter.sv
// Scoreboard bench: two arbiters (round-robin and fixed priority) share all inputs;
// expected memory requests and completions are queued per instance and popped by a monitor.
module tb_miriscv_dmem_arbiter;

   typedef struct packed {
      logic        m;
      logic [31:0] rdata;
   } cpl_t;

   typedef struct packed {
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mreq_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_i;
   logic        m0_req, m1_req, m0_we, m1_we;
   logic [3:0]  m0_be, m1_be;
   logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, data_rdata;

   // index 0: ROUND_ROBIN=1 instance, index 1: ROUND_ROBIN=0 instance
   logic [1:0]  m0_stall, m1_stall, m0_rvalid, m1_rvalid, data_req, data_we;
   logic [31:0] m0_rdata [2];
   logic [31:0] m1_rdata [2];
   logic [3:0]  data_be [2];
   logic [31:0] data_addr [2];
   logic [31:0] data_wdata [2];

   cpl_t  cq0[$], cq1[$];
   mreq_t mq0[$], mq1[$];
   cpl_t  ce;
   mreq_t me;
   int    compared   = 0;
   int    mismatched = 0;

   miriscv_dmem_arbiter #(.ROUND_ROBIN(1)) u_rr (
      .clk(clk), .rst_i(rst_i),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
      .m0_stall_o(m0_stall[0]), .m0_rvalid_o(m0_rvalid[0]), .m0_rdata_o(m0_rdata[0]),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
      .m1_stall_o(m1_stall[0]), .m1_rvalid_o(m1_rvalid[0]), .m1_rdata_o(m1_rdata[0]),
      .data_req_o(data_req[0]), .data_we_o(data_we[0]), .data_be_o(data_be[0]),
      .data_addr_o(data_addr[0]), .data_wdata_o(data_wdata[0]), .data_rdata_i(data_rdata)
   );

   miriscv_dmem_arbiter #(.ROUND_ROBIN(0)) u_fp (
      .clk(clk), .rst_i(rst_i),
      .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_be_i(m0_be), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
      .m0_stall_o(m0_stall[1]), .m0_rvalid_o(m0_rvalid[1]), .m0_rdata_o(m0_rdata[1]),
      .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_be_i(m1_be), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
      .m1_stall_o(m1_stall[1]), .m1_rvalid_o(m1_rvalid[1]), .m1_rdata_o(m1_rdata[1]),
      .data_req_o(data_req[1]), .data_we_o(data_we[1]), .data_be_o(data_be[1]),
      .data_addr_o(data_addr[1]), .data_wdata_o(data_wdata[1]), .data_rdata_i(data_rdata)
   );

   task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int d, input cpl_t c, input mreq_t r);
      if (d == 0) begin
         cq0.push_back(c);
         mq0.push_back(r);
      end else begin
         cq1.push_back(c);
         mq1.push_back(r);
      end
   endtask

   task automatic push_both(input cpl_t c, input mreq_t r);
      push(0, c, r);
      push(1, c, r);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_reqs();
      m0_req = 1'b0; m0_we = 1'b0; m0_be = 4'h0; m0_addr = 32'h0; m0_wdata = 32'h0;
      m1_req = 1'b0; m1_we = 1'b0; m1_be = 4'h0; m1_addr = 32'h0; m1_wdata = 32'h0;
   endtask

   // monitor: completions and memory-side requests against the per-instance queues
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (m0_rvalid[d] || m1_rvalid[d]) begin
            if ((d == 0 && cq0.size() == 0) || (d == 1 && cq1.size() == 0)) begin
               chk($sformatf("unexpected_rvalid_%0d", d), 72'(1), 72'(0));
            end else begin
               if (d == 0) ce = cq0.pop_front();
               else        ce = cq1.pop_front();
               chk($sformatf("completion_%0d", d),
                   72'({m0_rvalid[d], m1_rvalid[d],
                        m1_rvalid[d] ? m1_rdata[d] : m0_rdata[d],
                        m1_rvalid[d] ? m0_rdata[d] : m1_rdata[d]}),
                   72'({~ce.m, ce.m, ce.rdata, 32'h0}));
            end
         end else begin
            chk($sformatf("idle_rdata_%0d", d), 72'({m0_rdata[d], m1_rdata[d]}), 72'(0));
         end

         if (data_req[d]) begin
            if ((d == 0 && mq0.size() == 0) || (d == 1 && mq1.size() == 0)) begin
               chk($sformatf("unexpected_data_req_%0d", d), 72'(1), 72'(0));
            end else begin
               if (d == 0) me = mq0.pop_front();
               else        me = mq1.pop_front();
               chk($sformatf("mem_access_%0d", d),
                   72'({data_we[d], data_be[d], data_addr[d], data_wdata[d]}), 72'(me));
            end
         end else begin
            chk($sformatf("idle_data_%0d", d),
                72'({data_we[d], data_be[d], data_addr[d], data_wdata[d]}), 72'(0));
         end
      end
   end

   initial begin
      logic [3:0] exp_st;
      clr_reqs();
      rst_i      = 1'b1;
      data_rdata = 32'h0;
      step();
      step();

      // reset with a request present: only stall may be visible
      m0_req  = 1'b1;
      m0_addr = 32'h100;
      @(negedge clk);
      chk("rst_stall", 72'({m0_stall, m1_stall}), 72'(4'b1100));
      chk("rst_data_req", 72'(data_req), 72'(0));
      chk("rst_rvalid", 72'({m0_rvalid, m1_rvalid}), 72'(0));
      step();
      clr_reqs();
      rst_i = 1'b0;
      step();

      // m0 read 0x100 -> DEADBEEF
      m0_req = 1'b1; m0_we = 1'b0; m0_be = 4'hF; m0_addr = 32'h100; m0_wdata = 32'h0;
      data_rdata = 32'hDEADBEEF;
      push_both(cpl_t'{1'b0, 32'hDEADBEEF}, mreq_t'{1'b0, 4'hF, 32'h100, 32'h0});
      @(negedge clk);
      chk("rd_c1_stall", 72'({m0_stall, m1_stall}), 72'(4'b1100));
      chk("rd_c1_data_req", 72'(data_req), 72'(0));
      step();
      @(negedge clk);
      chk("rd_c2_data_req", 72'(data_req), 72'(2'b11));
      chk("rd_c2_stall", 72'({m0_stall, m1_stall}), 72'(4'b1100));
      step();
      @(negedge clk);
      chk("rd_c3_rvalid", 72'(m0_rvalid), 72'(2'b11));
      chk("rd_c3_stall", 72'({m0_stall, m1_stall}), 72'(4'b0000));
      clr_reqs();
      step();

      // m1 write 0x204, be 1100: rdata must come back as zero
      m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'b1100; m1_addr = 32'h204; m1_wdata = 32'h12340000;
      data_rdata = 32'hFFFFFFFF;
      push_both(cpl_t'{1'b1, 32'h0}, mreq_t'{1'b1, 4'b1100, 32'h204, 32'h12340000});
      step();
      @(negedge clk);
      chk("wr_access", 72'(data_req), 72'(2'b11));
      step();
      @(negedge clk);
      chk("wr_rvalid", 72'({m1_rvalid, m1_stall}), 72'(4'b1100));
      clr_reqs();
      step();

      // tie from reset, held: round-robin alternates, fixed priority starves m1
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      m0_req = 1'b1; m0_we = 1'b0; m0_be = 4'hF; m0_addr = 32'h10;
      m1_req = 1'b1; m1_we = 1'b1; m1_be = 4'h3; m1_addr = 32'h20; m1_wdata = 32'hA5A5A5A5;
      data_rdata = 32'h0BADF00D;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) push(0, cpl_t'{1'b0, 32'h0BADF00D}, mreq_t'{1'b0, 4'hF, 32'h10, 32'h0});
         else            push(0, cpl_t'{1'b1, 32'h0}, mreq_t'{1'b1, 4'h3, 32'h20, 32'hA5A5A5A5});
         push(1, cpl_t'{1'b0, 32'h0BADF00D}, mreq_t'{1'b0, 4'hF, 32'h10, 32'h0});
      end
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         exp_st = {(c % 3) != 0, !(c == 3 || c == 9), 1'b1, !(c == 6 || c == 12)};
         chk($sformatf("tie_stall_c%0d", c), 72'({m0_stall, m1_stall}), 72'(exp_st));
         if (c == 12) clr_reqs();
         step();
      end

      // m0 drops req during ACCESS with be=0: still completes, no second access
      m0_req = 1'b1; m0_we = 1'b0; m0_be = 4'h0; m0_addr = 32'h40;
      data_rdata = 32'h55AA55AA;
      push_both(cpl_t'{1'b0, 32'h55AA55AA}, mreq_t'{1'b0, 4'h0, 32'h40, 32'h0});
      step();
      m0_req = 1'b0;
      @(negedge clk);
      chk("drop_access", 72'({data_req, m0_stall}), 72'(4'b1100));
      step();
      @(negedge clk);
      chk("drop_rvalid", 72'(m0_rvalid), 72'(2'b11));
      step();
      step();
      step();
      @(negedge clk);
      chk("drop_no_reissue", 72'(data_req), 72'(0));
      step();

      // reset during ACCESS: access discarded, following tie goes to m0
      m0_req = 1'b1; m0_we = 1'b0; m0_be = 4'hF; m0_addr = 32'h30;
      data_rdata = 32'h13572468;
      step();
      rst_i = 1'b1;
      @(negedge clk);
      chk("rst_mid_quiet", 72'({data_req, m0_stall}), 72'(4'b0011));
      step();
      rst_i = 1'b0;
      m1_req = 1'b1; m1_we = 1'b0; m1_be = 4'hF; m1_addr = 32'h50;
      push_both(cpl_t'{1'b0, 32'h13572468}, mreq_t'{1'b0, 4'hF, 32'h30, 32'h0});
      push_both(cpl_t'{1'b1, 32'h13572468}, mreq_t'{1'b0, 4'hF, 32'h50, 32'h0});
      @(negedge clk);
      chk("rst_mid_idle", 72'({data_req, m0_rvalid}), 72'(0));
      step();
      step();
      m0_req = 1'b0;
      step();
      step();
      step();
      m1_req = 1'b0;
      step();
      step();
      step();

      @(negedge clk);
      chk("cq0_drained", 72'(cq0.size()), 72'(0));
      chk("cq1_drained", 72'(cq1.size()), 72'(0));
      chk("mq0_drained", 72'(mq0.size()), 72'(0));
      chk("mq1_drained", 72'(mq1.size()), 72'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
